// File: rtl/mem_port_arb_pkg.sv
// ----------------------------------------------------------------------------
// utils_top : types and constants shared by the memory port arbiter files.
//
//   arb_state_e : owner of the response that is due this cycle
//   rsp_t       : one requester's response bundle (rvalid / err / rdata)
//   BE_FULL     : byte enables used for every full-word access
//   STARVE_W    : width of the fetch starvation counter
// ----------------------------------------------------------------------------
package utils_top;

   localparam logic [3:0] BE_FULL  = 4'hF;
   localparam int         STARVE_W = 4;

   typedef enum logic [2:0] {
      IDLE,     // nothing owed this cycle
      IF_PEND,  // fetch read issued last cycle
      LS_PEND,  // LS read issued last cycle
      ERR_IF,   // out-of-bounds fetch accepted last cycle
      ERR_LS    // out-of-bounds LS access accepted last cycle
   } arb_state_e;

   typedef struct packed {
      logic        rvalid;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   // Increment that sticks at lim.
   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                   input logic [STARVE_W-1:0] lim);
      return (v >= lim) ? lim : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_port_arb_oob_chk.sv
// ----------------------------------------------------------------------------
// mem_port_arb_oob_chk : combinational bounds/alignment check of one byte
// address against a memory of 2**MEM_BYTE_ADD_W bytes.
//
//   addr : byte address of the request
//   oob  : 1 when any bit above the memory range is set or the address is not
//          word aligned
// ----------------------------------------------------------------------------
module mem_port_arb_oob_chk #(
   parameter int MEM_BYTE_ADD_W = 8
) (
   input  logic [31:0] addr,
   output logic        oob
);

   // Ones on every address bit that lies above the memory.
   localparam logic [31:0] HI_MASK = ~((32'd1 << MEM_BYTE_ADD_W) - 32'd1);

   assign oob = (|(addr & HI_MASK)) | (|addr[1:0]);

endmodule

// File: rtl/mem_port_arb.sv
// ----------------------------------------------------------------------------
// mem_port_arb : shares one single-port synchronous memory between the fetch
// unit (read only) and the load/store unit (read/write).
//
//   clk, rst_n            clock, asynchronous active-low reset
//   if_req/if_addr        fetch request             -> if_gnt
//   if_rvalid/rdata/err   fetch response, one cycle after the grant
//   ls_req/we/be/addr/
//   ls_wdata              LS request                -> ls_gnt
//   ls_rvalid/rdata/err   LS response, one cycle after the grant
//                         (rvalid for reads only, err for reads and writes)
//   mem_*                 memory macro command, mem_rdata returns a cycle later
//
// LS has priority, except when it has already won STARVE_MAX cycles in a row
// against a waiting fetch; then fetch is forced through once.
// Out-of-bounds requests are accepted but never reach the memory; their
// owner sees err (and rvalid with zero data for reads) on the next cycle.
//
// Optional build macro MEM_PORT_ARB_PERF_CNT_EN adds perf_if_wait and
// perf_ls_wait, saturating counts of cycles each requester spent waiting.
// ----------------------------------------------------------------------------
module mem_port_arb
   import utils_top::*;
#(
   parameter int MEM_BYTE_ADD_W = 8,
   parameter int STARVE_MAX     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      if_req,
   input  logic [31:0]               if_addr,
   output logic                      if_gnt,
   output logic                      if_rvalid,
   output logic [31:0]               if_rdata,
   output logic                      if_err,
   input  logic                      ls_req,
   input  logic                      ls_we,
   input  logic [3:0]                ls_be,
   input  logic [31:0]               ls_addr,
   input  logic [31:0]               ls_wdata,
   output logic                      ls_gnt,
   output logic                      ls_rvalid,
   output logic [31:0]               ls_rdata,
   output logic                      ls_err,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [3:0]                mem_be,
   output logic [MEM_BYTE_ADD_W-3:0] mem_addr,
   output logic [31:0]               mem_wdata,
   input  logic [31:0]               mem_rdata
`ifdef MEM_PORT_ARB_PERF_CNT_EN
   ,
   output logic [31:0]               perf_if_wait,
   output logic [31:0]               perf_ls_wait
`endif
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   logic                if_oob, ls_oob;
   logic                fetch_force;
   logic [STARVE_W-1:0] starve_q, starve_d;
   arb_state_e          state_q, state_d;
   logic                err_we_q, err_we_d;   // OOB LS access was a write
   rsp_t                if_rsp, ls_rsp;

   mem_port_arb_oob_chk #(.MEM_BYTE_ADD_W(MEM_BYTE_ADD_W)) u_if_oob (
      .addr (if_addr),
      .oob  (if_oob)
   );

   mem_port_arb_oob_chk #(.MEM_BYTE_ADD_W(MEM_BYTE_ADD_W)) u_ls_oob (
      .addr (ls_addr),
      .oob  (ls_oob)
   );

   // ---------------------------------------------------------------- grant
   // Grants are masked by rst_n so nothing is accepted while in reset.
   assign fetch_force = (starve_q == STARVE_LIM);
   assign if_gnt      = rst_n & if_req & (~ls_req | fetch_force);
   assign ls_gnt      = rst_n & ls_req & ~(if_req & fetch_force);

   // Counts LS wins against a waiting fetch; any cycle where fetch is not
   // waiting (granted or not requesting) starts the count over.
   always_comb begin
      starve_d = starve_q;
      if (if_gnt || !if_req)
         starve_d = '0;
      else if (ls_gnt)
         starve_d = sat_inc(starve_q, STARVE_LIM);
   end

   // ---------------------------------------------------------- memory drive
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (if_gnt && !if_oob) begin
         mem_en    = 1'b1;
         mem_be    = BE_FULL;
         mem_addr  = if_addr[MEM_BYTE_ADD_W-1:2];
         mem_wdata = ls_wdata;
      end else if (ls_gnt && !ls_oob) begin
         mem_en    = 1'b1;
         mem_we    = ls_we;
         mem_be    = ls_we ? ls_be : BE_FULL;
         mem_addr  = ls_addr[MEM_BYTE_ADD_W-1:2];
         mem_wdata = ls_wdata;
      end
   end

   // ------------------------------------------------------- response FSM
   // The state is entirely decided by this cycle's grant, so a new grant
   // can be accepted in the same cycle a previous response is delivered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         err_we_q <= 1'b0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         err_we_q <= err_we_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d  = IDLE;
      err_we_d = 1'b0;
      if (if_gnt) begin
         state_d = if_oob ? ERR_IF : IF_PEND;
      end else if (ls_gnt) begin
         if (ls_oob) begin
            state_d  = ERR_LS;
            err_we_d = ls_we;
         end else if (!ls_we) begin
            state_d = LS_PEND;
         end
      end
   end

   always_comb begin
      if_rsp = '0;
      ls_rsp = '0;
      unique case (state_q)
         IF_PEND: begin
            if_rsp.rvalid = 1'b1;
            if_rsp.rdata  = mem_rdata;
         end
         LS_PEND: begin
            ls_rsp.rvalid = 1'b1;
            ls_rsp.rdata  = mem_rdata;
         end
         ERR_IF: begin
            if_rsp.rvalid = 1'b1;
            if_rsp.err    = 1'b1;
         end
         ERR_LS: begin
            ls_rsp.rvalid = ~err_we_q;
            ls_rsp.err    = 1'b1;
         end
         default: ;
      endcase
   end

   assign if_rvalid = if_rsp.rvalid;
   assign if_err    = if_rsp.err;
   assign if_rdata  = if_rsp.rdata;
   assign ls_rvalid = ls_rsp.rvalid;
   assign ls_err    = ls_rsp.err;
   assign ls_rdata  = ls_rsp.rdata;

`ifdef MEM_PORT_ARB_PERF_CNT_EN
   // ------------------------------------------------------ wait counters
   logic [31:0] perf_if_q, perf_ls_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_if_q <= '0;
         perf_ls_q <= '0;
      end else begin
         if (if_req && !if_gnt && perf_if_q != '1)
            perf_if_q <= perf_if_q + 32'd1;
         if (ls_req && !ls_gnt && perf_ls_q != '1)
            perf_ls_q <= perf_ls_q + 32'd1;
      end
   end

   assign perf_if_wait = perf_if_q;
   assign perf_ls_wait = perf_ls_q;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;
   localparam int AW   = 8;
   localparam int SMAX = 4;
   localparam int NW   = 1 << (AW - 2);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata;
   logic [3:0]  ls_be;
   logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
   logic [31:0] if_rdata, ls_rdata;
   logic        mem_en, mem_we;
   logic [3:0]  mem_be;
   logic [AW-3:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
`ifdef MEM_PORT_ARB_PERF_CNT_EN
   logic [31:0] perf_if_wait, perf_ls_wait;
`endif

   int checks   = 0;
   int failures = 0;

   mem_port_arb #(.MEM_BYTE_ADD_W(AW), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
      .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARB_PERF_CNT_EN
      , .perf_if_wait(perf_if_wait), .perf_ls_wait(perf_ls_wait)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   // Memory macro: one access per cycle, read data registered.
   logic [31:0] mem_arr [NW];
   logic        mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < NW; i++) mem_arr[i] <= init_val(i);
         mem_ready <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem_arr[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else begin
            mem_rdata <= mem_arr[mem_addr];
         end
      end
   end

   // Shadow of what the memory should contain.
   logic [31:0] ref_mem [NW];

   function automatic bit is_oob(input logic [31:0] a);
      return (a >= 32'(NW * 4)) || (a % 4 != 0);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
   endtask

   task automatic test_reset();
      if_req = 1; ls_req = 1; if_addr = 32'h10; ls_addr = 32'h14;
      #1;
      checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL reset_if_gnt got=%0b exp=0", if_gnt); end
      checks++; if (ls_gnt !== 1'b0) begin failures++; $display("FAIL reset_ls_gnt got=%0b exp=0", ls_gnt); end
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%0b exp=0", mem_en); end
      checks++; if ({if_rvalid, if_err, ls_rvalid, ls_err} !== 4'b0) begin failures++;
         $display("FAIL reset_rsp got=%b exp=0000", {if_rvalid, if_err, ls_rvalid, ls_err}); end
      checks++; if ({if_rdata, ls_rdata} !== 64'b0) begin failures++;
         $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, ls_rdata); end
      idle_inputs();
   endtask

   task automatic test_fetch_alone();
      tick();
      if_req = 1; if_addr = 32'h10;
      #1;
      checks++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin failures++; $display("FAIL fetch_gnt got=%0b%0b exp=10", if_gnt, ls_gnt); end
      checks++; if ({mem_en, mem_we, mem_be} !== 6'b10_1111) begin failures++;
         $display("FAIL fetch_mem_ctl got=%b exp=101111", {mem_en, mem_we, mem_be}); end
      checks++; if (mem_addr !== 6'h4) begin failures++; $display("FAIL fetch_mem_addr got=%h exp=4", mem_addr); end
      tick();
      if_req = 0;
      checks++; if (if_rvalid !== 1'b1 || if_err !== 1'b0) begin failures++; $display("FAIL fetch_rvalid got=%0b%0b exp=10", if_rvalid, if_err); end
      checks++; if (if_rdata !== ref_mem[4]) begin failures++; $display("FAIL fetch_rdata got=%h exp=%h", if_rdata, ref_mem[4]); end
      checks++; if (ls_rvalid !== 1'b0 || ls_rdata !== 32'h0) begin failures++; $display("FAIL fetch_ls_quiet got=%0b %h exp=0 0", ls_rvalid, ls_rdata); end
      tick();
      checks++; if (if_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_rvalid_drop got=%0b exp=0", if_rvalid); end
   endtask

   task automatic test_contention();
      bit prev_ls;
      idle_inputs();
      tick();
      if_req = 1; if_addr = 32'h0;
      ls_req = 1; ls_we = 0; ls_addr = 32'h8;
      prev_ls = 0;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) begin
            checks++; if (ls_rvalid !== prev_ls || if_rvalid !== !prev_ls) begin failures++;
               $display("FAIL contend_rsp c=%0d got=%0b%0b exp=%0b%0b", c, ls_rvalid, if_rvalid, prev_ls, !prev_ls); end
            checks++; if ((prev_ls ? ls_rdata : if_rdata) !== (prev_ls ? ref_mem[2] : ref_mem[0])) begin failures++;
               $display("FAIL contend_rdata c=%0d got=%h", c, prev_ls ? ls_rdata : if_rdata); end
         end
         #1;
         prev_ls = (c != SMAX);
         checks++; if (ls_gnt !== prev_ls || if_gnt !== !prev_ls) begin failures++;
            $display("FAIL contend_gnt c=%0d got ls=%0b if=%0b exp ls=%0b", c, ls_gnt, if_gnt, prev_ls); end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_ls_write();
      logic [31:0] exp;
      ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h20; ls_wdata = 32'hDEADBEEF;
      #1;
      checks++; if (ls_gnt !== 1'b1 || {mem_en, mem_we, mem_be} !== 6'b11_0011) begin failures++;
         $display("FAIL wr_mem_ctl got=%0b %b exp=1 110011", ls_gnt, {mem_en, mem_we, mem_be}); end
      checks++; if (mem_addr !== 6'h8 || mem_wdata !== 32'hDEADBEEF) begin failures++;
         $display("FAIL wr_mem_data got=%h %h exp=8 deadbeef", mem_addr, mem_wdata); end
      ref_mem[8][15:0] = 16'hBEEF;
      exp = ref_mem[8];
      tick();
      ls_we = 0; ls_be = 0;
      checks++; if (ls_rvalid !== 1'b0 || ls_err !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid got=%0b%0b exp=00", ls_rvalid, ls_err); end
      #1;
      checks++; if (mem_we !== 1'b0 || mem_be !== 4'hF) begin failures++; $display("FAIL rd_mem_ctl got=%0b %h exp=0 f", mem_we, mem_be); end
      tick();
      idle_inputs();
      checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== exp) begin failures++; $display("FAIL wr_readback got=%0b %h exp=1 %h", ls_rvalid, ls_rdata, exp); end
      tick();
   endtask

   task automatic test_oob();
      if_req = 1; if_addr = 32'h100;
      #1;
      checks++; if (if_gnt !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL oob_if_gnt got=%0b en=%0b exp=1 0", if_gnt, mem_en); end
      tick();
      idle_inputs();
      checks++; if ({if_rvalid, if_err} !== 2'b11 || if_rdata !== 32'h0) begin failures++;
         $display("FAIL oob_if_rsp got=%0b%0b %h exp=11 0", if_rvalid, if_err, if_rdata); end
      ls_req = 1; ls_we = 0; ls_addr = 32'h2;
      #1;
      checks++; if (ls_gnt !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL oob_ls_gnt got=%0b en=%0b exp=1 0", ls_gnt, mem_en); end
      tick();
      checks++; if ({ls_rvalid, ls_err} !== 2'b11 || ls_rdata !== 32'h0) begin failures++;
         $display("FAIL oob_ls_rsp got=%0b%0b %h exp=11 0", ls_rvalid, ls_err, ls_rdata); end
      ls_we = 1; ls_be = 4'hF; ls_addr = 32'h8000_0000;
      #1;
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL oob_wr_en got=%0b exp=0", mem_en); end
      tick();
      idle_inputs();
      checks++; if ({ls_rvalid, ls_err} !== 2'b01) begin failures++; $display("FAIL oob_wr_rsp got=%0b%0b exp=01", ls_rvalid, ls_err); end
      tick();
      checks++; if (ls_err !== 1'b0) begin failures++; $display("FAIL oob_err_pulse got=%0b exp=0", ls_err); end
   endtask

   task automatic test_pipeline();
      if_req = 1; if_addr = 32'h40;
      #1;
      checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL pipe_if_gnt got=%0b exp=1", if_gnt); end
      tick();
      idle_inputs();
      ls_req = 1; ls_addr = 32'h44;
      checks++; if (if_rvalid !== 1'b1 || if_rdata !== ref_mem[16] || ls_rvalid !== 1'b0) begin failures++;
         $display("FAIL pipe_if_rsp got=%0b %h ls=%0b exp=1 %h 0", if_rvalid, if_rdata, ls_rvalid, ref_mem[16]); end
      #1;
      checks++; if (ls_gnt !== 1'b1 || mem_addr !== 6'h11) begin failures++; $display("FAIL pipe_ls_gnt got=%0b %h exp=1 11", ls_gnt, mem_addr); end
      tick();
      idle_inputs();
      checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== ref_mem[17] || if_rvalid !== 1'b0) begin failures++;
         $display("FAIL pipe_ls_rsp got=%0b %h if=%0b exp=1 %h 0", ls_rvalid, ls_rdata, if_rvalid, ref_mem[17]); end
      tick();
   endtask

   task automatic test_reset_mid();
      if_req = 1; if_addr = 32'h4;
      #1;
      checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL rmid_gnt got=%0b exp=1", if_gnt); end
      @(posedge clk);
      #1;
      if_req = 0;
      checks++; if (if_rvalid !== 1'b1) begin failures++; $display("FAIL rmid_pending got=%0b exp=1", if_rvalid); end
      rst_n = 0;
      #1;
      checks++; if (if_rvalid !== 1'b0) begin failures++; $display("FAIL rmid_drop got=%0b exp=0", if_rvalid); end
      @(negedge clk);
      rst_n = 1;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++; if (if_rvalid !== 1'b0) begin failures++; $display("FAIL rmid_after c=%0d got=%0b exp=0", c, if_rvalid); end
      end
   endtask

   function automatic logic [31:0] rand_addr();
      int r = $urandom_range(0, 9);
      if (r == 0) return 32'h100 << $urandom_range(0, 23);
      if (r == 1) return 32'($urandom_range(0, NW - 1) * 4 + $urandom_range(1, 3));
      return 32'($urandom_range(0, NW - 1) * 4);
   endfunction

   task automatic test_random();
      int          streak = 0;
      bit          hold_if = 0, hold_ls = 0, eg_if, eg_ls;
      logic        e_if_rv = 0, e_if_err = 0, e_ls_rv = 0, e_ls_err = 0;
      logic [31:0] e_if_dat = 0, e_ls_dat = 0;
      longint      wait_if = 0, wait_ls = 0;
      int          w;
      idle_inputs();
      rst_n = 0;
      tick();
      rst_n = 1;
      for (int n = 0; n < 400; n++) begin
         checks++; if ({if_rvalid, if_err, if_rdata} !== {e_if_rv, e_if_err, e_if_dat}) begin failures++;
            $display("FAIL rnd_if_rsp n=%0d got=%0b%0b %h exp=%0b%0b %h", n, if_rvalid, if_err, if_rdata, e_if_rv, e_if_err, e_if_dat); end
         checks++; if ({ls_rvalid, ls_err, ls_rdata} !== {e_ls_rv, e_ls_err, e_ls_dat}) begin failures++;
            $display("FAIL rnd_ls_rsp n=%0d got=%0b%0b %h exp=%0b%0b %h", n, ls_rvalid, ls_err, ls_rdata, e_ls_rv, e_ls_err, e_ls_dat); end
         if (!hold_if) begin
            if_req  = ($urandom_range(0, 99) < 60);
            if_addr = rand_addr();
         end
         if (!hold_ls) begin
            ls_req   = ($urandom_range(0, 99) < 60);
            ls_we    = 1'($urandom_range(0, 1));
            ls_be    = 4'($urandom);
            ls_addr  = rand_addr();
            ls_wdata = $urandom;
         end
         if (if_req && ls_req) begin
            eg_if = (streak == SMAX);
            eg_ls = !eg_if;
         end else begin
            eg_if = if_req;
            eg_ls = ls_req;
         end
         #1;
         checks++; if (if_gnt !== eg_if || ls_gnt !== eg_ls) begin failures++;
            $display("FAIL rnd_gnt n=%0d got if=%0b ls=%0b exp if=%0b ls=%0b", n, if_gnt, ls_gnt, eg_if, eg_ls); end
         e_if_rv = 0; e_if_err = 0; e_if_dat = 0; e_ls_rv = 0; e_ls_err = 0; e_ls_dat = 0;
         if (eg_if && !is_oob(if_addr)) begin
            w = int'(if_addr / 4);
            checks++; if ({mem_en, mem_we, mem_be} !== 6'b10_1111 || mem_addr !== 6'(w)) begin failures++;
               $display("FAIL rnd_mem_if n=%0d got=%b %h exp=101111 %h", n, {mem_en, mem_we, mem_be}, mem_addr, 6'(w)); end
            e_if_rv = 1; e_if_dat = ref_mem[w];
         end else if (eg_ls && !is_oob(ls_addr)) begin
            w = int'(ls_addr / 4);
            checks++; if ({mem_en, mem_we, mem_be} !== {1'b1, ls_we, ls_we ? ls_be : 4'hF} || mem_addr !== 6'(w)) begin failures++;
               $display("FAIL rnd_mem_ls n=%0d got=%b %h exp we=%0b addr=%h", n, {mem_en, mem_we, mem_be}, mem_addr, ls_we, 6'(w)); end
            if (ls_we) begin
               checks++; if (mem_wdata !== ls_wdata) begin failures++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, mem_wdata, ls_wdata); end
               for (int b = 0; b < 4; b++) if (ls_be[b]) ref_mem[w][b*8 +: 8] = ls_wdata[b*8 +: 8];
            end else begin
               e_ls_rv = 1; e_ls_dat = ref_mem[w];
            end
         end else begin
            checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rnd_mem_idle n=%0d got=%0b exp=0", n, mem_en); end
            if (eg_if) begin e_if_rv = 1; e_if_err = 1; end
            if (eg_ls) begin e_ls_rv = !ls_we; e_ls_err = 1; end
         end
         if (eg_if || !if_req) streak = 0;
         else if (streak < SMAX) streak++;
         if (if_req && !eg_if) wait_if++;
         if (ls_req && !eg_ls) wait_ls++;
         hold_if = if_req && !eg_if;
         hold_ls = ls_req && !eg_ls;
         tick();
      end
`ifdef MEM_PORT_ARB_PERF_CNT_EN
      checks++; if (perf_if_wait !== 32'(wait_if) || perf_ls_wait !== 32'(wait_ls)) begin failures++;
         $display("FAIL rnd_perf got=%0d/%0d exp=%0d/%0d", perf_if_wait, perf_ls_wait, wait_if, wait_ls); end
`endif
      idle_inputs();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < NW; i++) ref_mem[i] = init_val(i);
      rst_n = 0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      rst_n = 1;
      test_fetch_alone();
      test_contention();
      test_ls_write();
      test_oob();
      test_pipeline();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Sequences one single-port synchronous instruction/data memory between two requesters: the fetch unit (read-only) and the load/store unit (read/write).
- Sits between fetch/LSU and the shared memory macro.
- Grants one requester per cycle, routes returned read data to the owner one cycle later, and flags out-of-bounds accesses.
- Bounds load/store starvation of fetch with a consecutive-grant counter.

Parameters:
- MEM_BYTE_ADD_W, 8, byte address width of the shared memory; word address = addr[MEM_BYTE_ADD_W-1:2].
- STARVE_MAX, 4, max consecutive LS grants while fetch is waiting before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- if_err  out  1  fetch access out-of-bounds, qualified by if_rvalid
- ls_req  in  1  load/store request
- ls_we  in  1  1 = write, 0 = read
- ls_be  in  4  write byte enables
- ls_addr  in  32  LS byte address
- ls_wdata  in  32  write data
- ls_gnt  out  1  LS request accepted this cycle
- ls_rvalid  out  1  LS read data valid (reads only)
- ls_rdata  out  32  LS read data
- ls_err  out  1  LS out-of-bounds, one-cycle pulse one cycle after the grant (reads and writes)
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  MEM_BYTE_ADD_W-2  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en & !mem_we

Behaviour:
- Handshake:
  - A request is accepted when its req and gnt are high in the same cycle. gnt is combinational from req and registered state.
  - Requesters hold req, addr and data stable until granted.
  - At most one gnt per cycle.
- Arbitration (cycle with both requests):
  - LS wins, unless starve_cnt == STARVE_MAX; then fetch wins.
  - A single requester is always granted. No bubbles: back-to-back grants every cycle.
- starve_cnt (4 bits, reset 0):
  - Increments on an LS grant while if_req is high.
  - Clears on an if grant, or when if_req is low.
  - Saturates at STARVE_MAX.
- Out-of-bounds: any addr bit [31:MEM_BYTE_ADD_W] set, or addr[1:0] != 0.
  - The request is still granted, but mem_en stays 0.
  - Next cycle the owner's rvalid (reads) and err = 1, with rdata = 0.
  - An OOB LS write gives ls_err = 1 with no rvalid.
- Memory drive on an in-bounds grant:
  - mem_en = 1; mem_we = ls_we for LS, 0 for fetch.
  - mem_be = ls_be for LS writes, 4'hF otherwise.
  - mem_addr = addr[MEM_BYTE_ADD_W-1:2].
  - mem_wdata = ls_wdata.
  - With no grant: mem_en = 0 and the other mem_* outputs are 0.
- Response FSM (registered owner of the outstanding read), states:
  - IDLE: no outstanding read.
  - IF_PEND: fetch read issued last cycle.
  - LS_PEND: LS read issued last cycle.
  - ERR_IF / ERR_LS: OOB access accepted last cycle.
- FSM transitions:
  - Next state is set by this cycle's grant: fetch read → IF_PEND; LS read → LS_PEND; LS write in-bounds → IDLE; OOB → ERR_*; no grant → IDLE.
- FSM outputs:
  - IF_PEND: if_rvalid = 1, if_rdata = mem_rdata.
  - LS_PEND: same on the LS side.
  - ERR_*: rvalid/err as described under out-of-bounds.
  - Non-owner rdata = 0.
- Latency: read data exactly 1 cycle after grant. Responses pipeline with new grants in the same cycle.
- Reset:
  - All outputs 0, FSM = IDLE, starve_cnt = 0.
  - Reset mid-operation drops any outstanding read; no rvalid after reset release.

Optional Feature:
- MEM_PORT_ARB_PERF_CNT_EN: adds outputs perf_if_wait (32) and perf_ls_wait (32).
  - Each is a saturating count of cycles its requester had req=1 and gnt=0. Reset 0; counts stick at 32'hFFFF_FFFF.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package utils_top receives:
  - the arbiter state enum (IDLE, IF_PEND, LS_PEND, ERR_IF, ERR_LS);
  - the constant BE_FULL = 4'hF.
- One natural sub-module: mem_port_arb_oob_chk, a combinational address range/alignment check parameterised by MEM_BYTE_ADD_W, instantiated once per requester.

Test Plan:
- Fetch alone: if_req=1, if_addr=0x10 → if_gnt same cycle, mem_addr=0x4; next cycle if_rvalid=1, if_rdata=mem_rdata.
- Contention with STARVE_MAX=4: if_req and ls_req (read) held high → ls_gnt for 4 consecutive cycles, if_gnt on the 5th, starve_cnt back to 0.
- LS write: ls_we=1, ls_be=4'b0011, ls_addr=0x20, ls_wdata=0xDEADBEEF → mem_we=1, mem_be=4'b0011, mem_addr=0x8; no ls_rvalid next cycle.
- OOB: if_addr=0x100 with MEM_BYTE_ADD_W=8 → if_gnt=1, mem_en=0; next cycle if_rvalid=1, if_err=1, if_rdata=0. Misaligned ls_addr=0x2 read → ls_rvalid=1, ls_err=1.
- Pipelining: fetch read granted at cycle N, LS read at N+1 → if_rvalid at N+1 and ls_rvalid at N+2, each with the correct data.
- Reset mid-operation: assert rst_n=0 while IF_PEND → if_rvalid=0 immediately and stays 0 after release until a new grant.
